// File: rtl/sap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sap_ctrl_pkg
// Shared constants for the SAP-class control sequencer: opcode encodings
// (upper nibble of the instruction register), control-word bit positions and
// the control-word width.
// Control word bit order, MSB..LSB:
//   {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi}
// -----------------------------------------------------------------------------
package sap_ctrl_pkg;

    localparam int CTRL_W = 16;

    // Control-word bit indices
    localparam int CTRL_HLT = 15;  // halt clock
    localparam int CTRL_MI  = 14;  // memory address register in
    localparam int CTRL_RI  = 13;  // RAM in (write)
    localparam int CTRL_RO  = 12;  // RAM out
    localparam int CTRL_IO  = 11;  // instruction register operand out
    localparam int CTRL_II  = 10;  // instruction register in
    localparam int CTRL_AI  = 9;   // A register in
    localparam int CTRL_AO  = 8;   // A register out
    localparam int CTRL_EO  = 7;   // ALU (sum) out
    localparam int CTRL_SU  = 6;   // ALU subtract
    localparam int CTRL_BI  = 5;   // B register in
    localparam int CTRL_OI  = 4;   // output register in
    localparam int CTRL_CE  = 3;   // program counter enable (increment)
    localparam int CTRL_CO  = 2;   // program counter out
    localparam int CTRL_J   = 1;   // jump (program counter in)
    localparam int CTRL_FI  = 0;   // flags register in

    // Opcodes; 4'h9..4'hD are unassigned and execute as NOP
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/sap_step_counter.sv
// -----------------------------------------------------------------------------
// sap_step_counter
// T-state register for the control sequencer. Counts 0..NUM_STEPS-1 and wraps,
// can be forced back to T0 early (restart), and holds its value while frozen
// (halt).
// Ports:
//   clk      in   system clock, rising edge
//   clr      in   asynchronous active-low reset (step -> 0)
//   advance  in   move to the next T-state this edge
//   restart  in   return to T0 this edge (instruction finished early)
//   freeze   in   hold the current T-state (highest priority after clr)
//   step     out  current T-state
// -----------------------------------------------------------------------------
module sap_step_counter #(
    parameter int NUM_STEPS = 5,
    parameter int STEP_W    = $clog2(NUM_STEPS)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              advance,
    input  logic              restart,
    input  logic              freeze,
    output logic [STEP_W-1:0] step
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            step <= '0;
        end else if (!freeze) begin
            if (restart || (advance && step == LAST_STEP)) begin
                step <= '0;
            end else if (advance) begin
                step <= step + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
// Microcoded control unit of the SAP-class 8-bit computer. Steps through
// fetch (T0, T1) and execute (T2..T4) and decodes the opcode plus the latched
// carry/zero flags into the control word driving every bus enable and
// register load in the datapath. The datapath samples ctrl on the same rising
// edge that advances step.
// Parameters:
//   NUM_STEPS  T-states per instruction (step width = clog2(NUM_STEPS))
//   EARLY_END  1: return to T0 right after the last active microstep
//              0: always run through T(NUM_STEPS-1)
// Ports:
//   clk     in   system clock, rising edge
//   clr     in   asynchronous active-low reset
//   opcode  in   upper nibble of the instruction register
//   carry   in   latched carry flag
//   zero    in   latched zero flag
//   ctrl    out  control word {hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi}
//   step    out  current T-state (debug/LEDs)
//   halted  out  high once HLT has executed, until clr
// -----------------------------------------------------------------------------
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic [3:0]                   opcode,
    input  logic                         carry,
    input  logic                         zero,
    output logic [CTRL_W-1:0]            ctrl,
    output logic [$clog2(NUM_STEPS)-1:0] step,
    output logic                         halted
);

    localparam int STEP_W = $clog2(NUM_STEPS);

    localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

    logic last_step;  // current microstep is the opcode's last active one
    logic hlt_exec;   // HLT is executing in T2 this cycle
    logic restart;
    logic freeze;

    // -------------------------------------------------------------------------
    // Microcode decode
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case, so
    // paths that do not mention a signal cannot infer a latch.
    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        hlt_exec  = 1'b0;

        if (halted) begin
            ctrl[CTRL_HLT] = 1'b1;
        end else begin
            case (step)
                T0: begin
                    ctrl[CTRL_CO] = 1'b1;
                    ctrl[CTRL_MI] = 1'b1;
                end
                T1: begin
                    ctrl[CTRL_RO] = 1'b1;
                    ctrl[CTRL_II] = 1'b1;
                    ctrl[CTRL_CE] = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl[CTRL_IO] = 1'b1;
                            ctrl[CTRL_MI] = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl[CTRL_IO] = 1'b1;
                            ctrl[CTRL_AI] = 1'b1;
                            last_step     = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl[CTRL_IO] = 1'b1;
                            ctrl[CTRL_J]  = 1'b1;
                            last_step     = 1'b1;
                        end
                        // Flags only matter here: the branch is resolved in T2
                        // and the instruction ends whether taken or not.
                        OP_JC: begin
                            ctrl[CTRL_IO] = carry;
                            ctrl[CTRL_J]  = carry;
                            last_step     = 1'b1;
                        end
                        OP_JZ: begin
                            ctrl[CTRL_IO] = zero;
                            ctrl[CTRL_J]  = zero;
                            last_step     = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl[CTRL_AO] = 1'b1;
                            ctrl[CTRL_OI] = 1'b1;
                            last_step     = 1'b1;
                        end
                        OP_HLT: begin
                            ctrl[CTRL_HLT] = 1'b1;
                            hlt_exec       = 1'b1;
                            last_step      = 1'b1;
                        end
                        // NOP and unassigned opcodes: empty execute phase
                        default: last_step = 1'b1;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ctrl[CTRL_RO] = 1'b1;
                            ctrl[CTRL_AI] = 1'b1;
                            last_step     = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl[CTRL_RO] = 1'b1;
                            ctrl[CTRL_BI] = 1'b1;
                        end
                        OP_STA: begin
                            ctrl[CTRL_AO] = 1'b1;
                            ctrl[CTRL_RI] = 1'b1;
                            last_step     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            ctrl[CTRL_EO] = 1'b1;
                            ctrl[CTRL_AI] = 1'b1;
                            ctrl[CTRL_SU] = (opcode == OP_SUB);
                            ctrl[CTRL_FI] = 1'b1;
                            last_step     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Step sequencing and halt
    // -------------------------------------------------------------------------
    assign restart = EARLY_END && last_step;

    // Freeze already during the HLT microstep so step stays at T2 on the very
    // edge that sets halted.
    assign freeze = halted || hlt_exec;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            halted <= 1'b0;
        end else if (hlt_exec) begin
            halted <= 1'b1;
        end
    end

    sap_step_counter #(
        .NUM_STEPS (NUM_STEPS),
        .STEP_W    (STEP_W)
    ) u_step_counter (
        .clk     (clk),
        .clr     (clr),
        .advance (1'b1),
        .restart (restart),
        .freeze  (freeze),
        .step    (step)
    );

endmodule

// File: tb/tb_sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_control_sequencer
// Directed bench for sap_control_sequencer. Two instances share all inputs:
// dut (EARLY_END=1) and dut_full (EARLY_END=0). Outputs are sampled 1 time
// unit after each rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_sap_control_sequencer;

    // Control-word bits, written out by hand from the documented bit order
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    localparam logic [15:0] FETCH0 = CO | MI;
    localparam logic [15:0] FETCH1 = RO | II | CE;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  opcode;
    logic        carry;
    logic        zero;

    logic [15:0] dut_ctrl,   full_ctrl;
    logic [2:0]  dut_step,   full_step;
    logic        dut_halted, full_halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sap_control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .carry  (carry),
        .zero   (zero),
        .ctrl   (dut_ctrl),
        .step   (dut_step),
        .halted (dut_halted)
    );

    sap_control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut_full (
        .clk    (clk),
        .clr    (clr),
        .opcode (opcode),
        .carry  (carry),
        .zero   (zero),
        .ctrl   (full_ctrl),
        .step   (full_step),
        .halted (full_halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse clr between edges; both instances come out at T0 with 3 time
    // units to spare before the next rising edge.
    task automatic apply_reset();
        @(negedge clk);
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (dut_step !== 3'd0 || dut_halted !== 1'b0 || dut_ctrl !== FETCH0) begin
            failures++;
            $display("FAIL reset_ee1: step=%0d halted=%b ctrl=%h expected step=0 halted=0 ctrl=%h",
                     dut_step, dut_halted, dut_ctrl, FETCH0);
        end
        checks++;
        if (full_step !== 3'd0 || full_halted !== 1'b0 || full_ctrl !== FETCH0) begin
            failures++;
            $display("FAIL reset_ee0: step=%0d halted=%b ctrl=%h expected step=0 halted=0 ctrl=%h",
                     full_step, full_halted, full_ctrl, FETCH0);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    // LDA/STA/ADD on the early-ending instance
    task automatic test_memory_ops();
        logic [3:0]  ops [3] = '{4'h1, 4'h4, 4'h2};
        logic [15:0] exp_c [3][6] = '{
            '{FETCH0, FETCH1, IO | MI, RO | AI, FETCH0, FETCH1},
            '{FETCH0, FETCH1, IO | MI, AO | RI, FETCH0, FETCH1},
            '{FETCH0, FETCH1, IO | MI, RO | BI, EO | AI | FI, FETCH0}};
        logic [2:0]  exp_s [3][6] = '{
            '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1},
            '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1},
            '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0}};
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            apply_reset();
            for (int i = 0; i < 6; i++) begin
                if (i > 0) tick();
                checks++;
                if (dut_ctrl !== exp_c[k][i] || dut_step !== exp_s[k][i]) begin
                    failures++;
                    $display("FAIL mem_op%h_%0d: ctrl=%h step=%0d expected ctrl=%h step=%0d",
                             ops[k], i, dut_ctrl, dut_step, exp_c[k][i], exp_s[k][i]);
                end
            end
        end
    endtask

    // SUB on the full-length instance: T4 carries su, then 4 -> 0
    task automatic test_sub_full();
        logic [15:0] exp_c [6] = '{FETCH0, FETCH1, IO | MI, RO | BI, EO | AI | SU | FI, FETCH0};
        opcode = 4'h3;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (full_ctrl !== exp_c[i] || full_step !== 3'((i == 5) ? 0 : i)) begin
                failures++;
                $display("FAIL sub_full_%0d: ctrl=%h step=%0d expected ctrl=%h step=%0d",
                         i, full_ctrl, full_step, exp_c[i], (i == 5) ? 0 : i);
            end
        end
    endtask

    // LDI/JMP/OUT: single execute microstep, back to T0 after T2
    task automatic test_short_ops();
        logic [3:0]  ops [3]   = '{4'h5, 4'h6, 4'hE};
        logic [15:0] exp_t2 [3] = '{IO | AI, IO | J, AO | OI};
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            apply_reset();
            tick();
            tick();
            checks++;
            if (dut_ctrl !== exp_t2[k] || dut_step !== 3'd2) begin
                failures++;
                $display("FAIL short_op%h_t2: ctrl=%h step=%0d expected ctrl=%h step=2",
                         ops[k], dut_ctrl, dut_step, exp_t2[k]);
            end
            tick();
            checks++;
            if (dut_ctrl !== FETCH0 || dut_step !== 3'd0) begin
                failures++;
                $display("FAIL short_op%h_end: ctrl=%h step=%0d expected ctrl=%h step=0",
                         ops[k], dut_ctrl, dut_step, FETCH0);
            end
        end
    endtask

    // JC/JZ taken and not taken; flags only matter during T2
    task automatic test_branches();
        logic [3:0]  ops [4]  = '{4'h7, 4'h7, 4'h8, 4'h8};
        logic        cy [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        zr [4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [15:0] exp_t2 [4] = '{IO | J, 16'h0000, IO | J, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            carry  = cy[k];
            zero   = zr[k];
            apply_reset();
            tick();
            tick();
            checks++;
            if (dut_ctrl !== exp_t2[k] || dut_step !== 3'd2) begin
                failures++;
                $display("FAIL branch%0d_t2: ctrl=%h step=%0d expected ctrl=%h step=2",
                         k, dut_ctrl, dut_step, exp_t2[k]);
            end
            // Flip both flags after T2: the full-length instance sits in T3
            // and must stay quiet.
            carry = ~carry;
            zero  = ~zero;
            tick();
            checks++;
            if (dut_ctrl !== FETCH0 || dut_step !== 3'd0) begin
                failures++;
                $display("FAIL branch%0d_end: ctrl=%h step=%0d expected ctrl=%h step=0",
                         k, dut_ctrl, dut_step, FETCH0);
            end
            checks++;
            if (full_ctrl !== 16'h0000 || full_step !== 3'd3) begin
                failures++;
                $display("FAIL branch%0d_t3_flags: ctrl=%h step=%0d expected ctrl=0000 step=3",
                         k, full_ctrl, full_step);
            end
        end
        carry = 1'b0;
        zero  = 1'b0;
    endtask

    // NOP and unassigned 1011 must give the same trace on both instances
    task automatic test_undefined();
        logic [3:0]  ops [2]      = '{4'h0, 4'hB};
        logic [15:0] exp_c_e [6]  = '{FETCH0, FETCH1, 16'h0, FETCH0, FETCH1, 16'h0};
        logic [2:0]  exp_s_e [6]  = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        logic [15:0] exp_c_f [6]  = '{FETCH0, FETCH1, 16'h0, 16'h0, 16'h0, FETCH0};
        logic [2:0]  exp_s_f [6]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            apply_reset();
            for (int i = 0; i < 6; i++) begin
                if (i > 0) tick();
                checks++;
                if (dut_ctrl !== exp_c_e[i] || dut_step !== exp_s_e[i] ||
                    full_ctrl !== exp_c_f[i] || full_step !== exp_s_f[i]) begin
                    failures++;
                    $display("FAIL nop_op%h_%0d: ctrl=%h/%h step=%0d/%0d expected ctrl=%h/%h step=%0d/%0d",
                             ops[k], i, dut_ctrl, full_ctrl, dut_step, full_step,
                             exp_c_e[i], exp_c_f[i], exp_s_e[i], exp_s_f[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        opcode = 4'hF;
        apply_reset();
        tick();
        tick();
        checks++;
        if (dut_ctrl !== HLT || dut_step !== 3'd2 || dut_halted !== 1'b0) begin
            failures++;
            $display("FAIL hlt_t2: ctrl=%h step=%0d halted=%b expected ctrl=%h step=2 halted=0",
                     dut_ctrl, dut_step, dut_halted, HLT);
        end
        tick();
        checks++;
        if (dut_halted !== 1'b1 || full_halted !== 1'b1) begin
            failures++;
            $display("FAIL hlt_set: halted=%b/%b expected 1/1", dut_halted, full_halted);
        end
        // Opcode wandering while halted must not matter
        opcode = 4'h2;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_ctrl !== HLT || dut_step !== 3'd2 || full_ctrl !== HLT || full_step !== 3'd2) begin
                failures++;
                $display("FAIL hlt_hold_%0d: ctrl=%h/%h step=%0d/%0d expected ctrl=%h step=2",
                         i, dut_ctrl, full_ctrl, dut_step, full_step, HLT);
            end
        end
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if (dut_halted !== 1'b0 || dut_step !== 3'd0 || dut_ctrl !== FETCH0 ||
            full_halted !== 1'b0 || full_step !== 3'd0) begin
            failures++;
            $display("FAIL hlt_clear: halted=%b/%b step=%0d/%0d ctrl=%h expected halted=0 step=0 ctrl=%h",
                     dut_halted, full_halted, dut_step, full_step, dut_ctrl, FETCH0);
        end
        @(negedge clk);
        clr = 1'b1;
    endtask

    // clr pulsed between edges while ADD sits in T3
    task automatic test_reset_mid();
        opcode = 4'h2;
        apply_reset();
        tick();
        tick();
        tick();
        checks++;
        if (dut_ctrl !== (RO | BI) || dut_step !== 3'd3) begin
            failures++;
            $display("FAIL mid_add_t3: ctrl=%h step=%0d expected ctrl=%h step=3",
                     dut_ctrl, dut_step, RO | BI);
        end
        #2;
        clr = 1'b0;
        #1;
        checks++;
        if (dut_step !== 3'd0 || dut_halted !== 1'b0 || dut_ctrl !== FETCH0 || full_step !== 3'd0) begin
            failures++;
            $display("FAIL mid_add_clr: step=%0d/%0d halted=%b ctrl=%h expected step=0 halted=0 ctrl=%h",
                     dut_step, full_step, dut_halted, dut_ctrl, FETCH0);
        end
        // Held low across an edge: still parked at T0
        tick();
        checks++;
        if (dut_step !== 3'd0 || dut_ctrl !== FETCH0) begin
            failures++;
            $display("FAIL mid_add_hold: step=%0d ctrl=%h expected step=0 ctrl=%h",
                     dut_step, dut_ctrl, FETCH0);
        end
        @(negedge clk);
        clr = 1'b1;
        // First edge after release performs T0's transfers
        tick();
        checks++;
        if (dut_step !== 3'd1 || dut_ctrl !== FETCH1) begin
            failures++;
            $display("FAIL mid_add_release: step=%0d ctrl=%h expected step=1 ctrl=%h",
                     dut_step, dut_ctrl, FETCH1);
        end
    endtask

    initial begin
        clr    = 1'b0;
        opcode = 4'h0;
        carry  = 1'b0;
        zero   = 1'b0;

        test_reset();
        test_memory_ops();
        test_sub_full();
        test_short_ops();
        test_branches();
        test_undefined();
        test_halt();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microcoded control sequencer for the SAP-class 8-bit computer. It steps a T-state counter through the fetch and execute phases. It decodes the opcode held in the upper nibble of the instruction register, together with the latched carry/zero flags, into the one-hot-per-signal control word. That control word drives the tristate/load pins of every bus-attached register, the ALU, the program counter, RAM and the output register. It sits between the instruction register/flags register and the rest of the datapath, and is the only source of bus enables.

## Interface
- NUM_STEPS, 5: T-states per instruction (T0..T4); step counter width is clog2(NUM_STEPS).
- EARLY_END, 1: when 1, the step counter returns to T0 right after an instruction's last active microstep; when 0, it always runs to T(NUM_STEPS-1).
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- opcode  in  4  upper nibble of the instruction register.
- carry  in  1  latched carry flag from the flags register.
- zero  in  1  latched zero flag from the flags register.
- ctrl  out  16  control word, bit order {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi}; all active-high.
- step  out  3  current T-state, exported for debug/LEDs.
- halted  out  1  high once HLT executes; low otherwise.

## Operation
- State: step register and a halted flag. Reset (clr low, at any time, including mid-instruction): step=0, halted=0, ctrl reflects the T0 decode, i.e. {co, mi}.
- ctrl is combinational from (step, opcode, carry, zero, halted). Datapath registers sample ctrl on the same rising edge that advances step.
- When halted=1, ctrl is all zeros except hlt, and step is frozen. Only clr exits this state.
- Fetch is opcode-independent:
  - T0: co, mi.
  - T1: ro, ii, ce.
- Execute microcode, T2/T3/T4:
  - NOP 0000: none.
  - LDA 0001: io,mi / ro,ai.
  - ADD 0010: io,mi / ro,bi / eo,ai,fi.
  - SUB 0011: io,mi / ro,bi / eo,ai,su,fi.
  - STA 0100: io,mi / ao,ri.
  - LDI 0101: io,ai.
  - JMP 0110: io,j.
  - JC 0111: io,j if carry=1, else none.
  - JZ 1000: io,j if zero=1, else none.
  - OUT 1110: ao,oi.
  - HLT 1111: hlt at T2; halted sets on that edge.
  - Opcodes 1001–1101: treated as NOP.
- Step advance: step ← step+1. Wrap to 0 after NUM_STEPS-1. With EARLY_END=1, step goes to 0 after the last non-empty microstep of the current opcode; for a NOP or an untaken JC/JZ, that is after T2.
- The flags are evaluated during T2 only. Flag changes at other steps have no effect on the branch.

## Timing
- One microstep per clock. The instruction cycle length follows from the step-advance rule:
  - EARLY_END=0: always NUM_STEPS clocks.
  - EARLY_END=1: NOP/LDI/JMP/OUT/untaken-branch take 3 clocks; LDA/STA take 4; ADD/SUB take 5.
- The opcode is sampled combinationally. It is guaranteed stable from the T1→T2 edge, because the instruction register loads on that edge via ii.
- HLT: halted rises on the edge that ends T2. From that point, hlt stays high and step holds at 2.
- Release of clr: the first rising edge after release performs T0's transfers.

## Structure
- Shared package sap_ctrl_pkg:
  - Opcode localparams.
  - Control-bit index constants (CTRL_HLT..CTRL_FI).
  - CTRL_W=16.
- Sub-module sap_step_counter: the step register plus the halt freeze. Inputs are clk, clr, advance, restart and freeze; output is step.
- Microcode decode stays in the top module as a single case block.

## Test plan
- Reset mid-ADD at T3, with clr pulsed low between edges → step=0, halted=0, ctrl={co,mi}, all asynchronously.
- LDA (0001) with EARLY_END=1 → ctrl sequence co|mi, ro|ii|ce, io|mi, ro|ai, then back to co|mi (4 clocks).
- SUB (0011) with EARLY_END=0 → T4 ctrl = eo|ai|su|fi, then step wraps 4→0.
- JC (0111):
  - carry=1 → T2 ctrl=io|j.
  - carry=0 → T2 ctrl=0, and step returns to 0 the next edge (EARLY_END=1).
- HLT (1111) → halted=1 after the T2 edge. Then for 10 clocks: ctrl=hlt only and step stays at 2. Then clr low → halted=0, step=0.
- Undefined opcode 1011 → identical ctrl and step trace to NOP.
